// File: rtl/dsp_pkg.sv
// dsp_pkg: constants and helpers shared by the audio output chain.
//   - Q-format constants. Samples are signed Q1.15 and gains are unsigned Q3.13.
//   - Q1.15 unity/ceiling constants and the Q3.13 unity gain.
//   - clamp_sym: symmetric hard clamp of a wide signed value to +/-ceiling.
//     It returns the narrowed sample together with a clip flag.
package dsp_pkg;

    localparam int W_TOTAL    = 16;   // sample width, signed Q1.15
    localparam int W_FRAC     = 15;   // sample fractional bits
    localparam int G_FRAC     = 13;   // gain fractional bits, unsigned Q3.13
    localparam int GAIN_W     = 16;   // gain register width
    localparam int CLAMP_IN_W = 40;   // widest intermediate accepted by clamp_sym

    localparam logic [W_TOTAL-1:0] Q15_MAX  = 16'h7FFF;  // largest Q1.15 value
    localparam logic [W_TOTAL-1:0] Q15_CEIL = 16'h7333;  // ~0.9 in Q1.15
    localparam logic [GAIN_W-1:0]  GAIN_ONE = 16'h2000;  // 1.0 in Q3.13

    typedef struct packed {
        logic [W_TOTAL-1:0] data;
        logic               clip;
    } clamp_t;

    // Clamp x to [-ceil_lin, +ceil_lin]. ceil_lin is a positive Q1.15 magnitude.
    // In-range values pass through truncated to W_TOTAL bits.
    function automatic clamp_t clamp_sym(input logic signed [CLAMP_IN_W-1:0] x,
                                         input logic [W_TOTAL-1:0]           ceil_lin);
        clamp_t                        res;
        logic signed [CLAMP_IN_W-1:0] hi;
        logic signed [CLAMP_IN_W-1:0] lo;
        hi = $signed({{(CLAMP_IN_W-W_TOTAL){1'b0}}, ceil_lin});
        lo = -hi;
        if (x > hi) begin
            res.data = ceil_lin;
            res.clip = 1'b1;
        end else if (x < lo) begin
            res.data = lo[W_TOTAL-1:0];
            res.clip = 1'b1;
        end else begin
            res.data = x[W_TOTAL-1:0];
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// gain_ramp: holds the target gain and the active gain.
// On every sample strobe it slews the active gain toward the target by at
// most GAIN_STEP.
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset; both gains return to DEFAULT_GAIN
//   i_ce       sample strobe; the active gain steps only on these cycles
//   i_gain_wr  loads i_gain into the target register (any cycle)
//   i_gain     unsigned Q3.13 target gain
//   o_gain     active gain, the value the current strobe's sample is scaled by
module gain_ramp
    import dsp_pkg::*;
#(
    parameter logic [GAIN_W-1:0] DEFAULT_GAIN = GAIN_ONE,
    parameter logic [GAIN_W-1:0] GAIN_STEP    = 16'h0100
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic              i_gain_wr,
    input  logic [GAIN_W-1:0] i_gain,
    output logic [GAIN_W-1:0] o_gain
);

    logic [GAIN_W-1:0] target;
    logic [GAIN_W-1:0] active;
    logic [GAIN_W-1:0] active_next;

    // The step decision compares distances instead of computing active+step.
    // This keeps the arithmetic in GAIN_W bits with no overflow near full scale.
    always_comb begin
        active_next = active;
        if (active < target) begin
            if ((target - active) > GAIN_STEP) begin
                active_next = active + GAIN_STEP;
            end else begin
                active_next = target;
            end
        end else if (active > target) begin
            if ((active - target) > GAIN_STEP) begin
                active_next = active - GAIN_STEP;
            end else begin
                active_next = target;
            end
        end
    end

    // A write coinciding with a strobe still steps toward the old target.
    // active_next was computed from the registered target.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            target <= DEFAULT_GAIN;
            active <= DEFAULT_GAIN;
        end else begin
            if (i_gain_wr) begin
                target <= i_gain;
            end
            if (i_ce) begin
                active <= active_next;
            end
        end
    end

    assign o_gain = active;

endmodule

// File: rtl/makeup_limiter.sv
// makeup_limiter: output stage after the compressor.
// It scales the Q1.15 stream by a ramped Q3.13 makeup gain and hard-limits
// the result to +/-CEIL_LIN. Clip activity is reported through a held flag
// and a saturating counter.
//
// Strobe convention: i_ce marks a valid input sample on that clock edge.
// There is no backpressure. o_ce pulses for exactly one cycle when o_data
// carries a new sample, two cycles after the matching i_ce cycle.
// Back-to-back i_ce is accepted at full rate.
//
//   i_clk         clock
//   i_reset_n     asynchronous active-low reset; in-flight samples are dropped
//   i_ce          input sample strobe
//   i_data        signed Q1.15 input sample
//   i_gain_wr     load i_gain as the new target gain
//   i_gain        unsigned Q3.13 target gain
//   i_clr_count   synchronous clear of the clip counter (wins over an increment)
//   o_data        limited Q1.15 sample, held between strobes
//   o_ce          output sample strobe
//   o_clip        high from a clipped sample through the next CLIP_HOLD samples
//   o_clip_count  saturating count of clipped output samples
module makeup_limiter
    import dsp_pkg::*;
#(
    parameter logic [GAIN_W-1:0]  DEFAULT_GAIN = GAIN_ONE,
    parameter logic [GAIN_W-1:0]  GAIN_STEP    = 16'h0100,
    parameter logic [W_TOTAL-1:0] CEIL_LIN     = Q15_CEIL,
    parameter int                 CLIP_HOLD    = 4800,
    parameter int                 CNT_W        = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    input  logic [W_TOTAL-1:0] i_data,
    input  logic               i_gain_wr,
    input  logic [GAIN_W-1:0]  i_gain,
    input  logic               i_clr_count,
    output logic [W_TOTAL-1:0] o_data,
    output logic               o_ce,
    output logic               o_clip,
    output logic [CNT_W-1:0]   o_clip_count
);

    localparam int HOLD_W = $clog2(CLIP_HOLD + 1);
    // 16-bit signed x 17-bit (zero-extended) signed gain fits in 33 bits (Q4.28)
    localparam int PROD_W = W_TOTAL + GAIN_W + 1;
    localparam logic [HOLD_W-1:0]        HOLD_LOAD  = HOLD_W'(CLIP_HOLD);
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1 << (G_FRAC - 1));

    // ---------------------------------------------------------------- gain
    logic [GAIN_W-1:0] gain;

    gain_ramp #(
        .DEFAULT_GAIN (DEFAULT_GAIN),
        .GAIN_STEP    (GAIN_STEP)
    ) u_gain_ramp (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_gain_wr (i_gain_wr),
        .i_gain    (i_gain),
        .o_gain    (gain)
    );

    // ------------------------------------------------------------- stage 1
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] p;
    logic                     valid1;

    assign data_ext = {{(PROD_W-W_TOTAL){i_data[W_TOTAL-1]}}, i_data};
    assign gain_ext = {{(PROD_W-GAIN_W){1'b0}}, gain};
    assign product  = data_ext * gain_ext;

    // ------------------------------------------------------------- stage 2
    logic signed [PROD_W-1:0] rounded;
    logic signed [PROD_W-1:0] shifted;
    clamp_t                   lim;

    // Round half up, then drop the gain's fractional bits.
    assign rounded = p + ROUND_BIAS;
    assign shifted = rounded >>> G_FRAC;
    assign lim     = clamp_sym(CLAMP_IN_W'(shifted), CEIL_LIN);

    // ------------------------------------------------- clip hold / counter
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;
    logic              clip_next;
    logic [CNT_W-1:0]  count_next;

    // The hold counter is advanced only on output samples.
    // o_clip follows the hold value before the decrement. A clip therefore
    // keeps the flag up on the clipped sample and on the CLIP_HOLD samples
    // after it.
    always_comb begin
        hold_next = hold;
        clip_next = o_clip;
        if (valid1) begin
            if (lim.clip) begin
                hold_next = HOLD_LOAD;
                clip_next = 1'b1;
            end else begin
                clip_next = (hold != '0);
                if (hold != '0) begin
                    hold_next = hold - HOLD_W'(1);
                end
            end
        end
    end

    always_comb begin
        count_next = o_clip_count;
        if (i_clr_count) begin
            count_next = '0;
        end else if (valid1 && lim.clip && (o_clip_count != '1)) begin
            count_next = o_clip_count + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p            <= '0;
            valid1       <= 1'b0;
            o_data       <= '0;
            o_ce         <= 1'b0;
            hold         <= '0;
            o_clip       <= 1'b0;
            o_clip_count <= '0;
        end else begin
            valid1 <= i_ce;
            if (i_ce) begin
                p <= product;
            end
            o_ce <= valid1;
            if (valid1) begin
                o_data <= lim.data;
            end
            hold         <= hold_next;
            o_clip       <= clip_next;
            o_clip_count <= count_next;
        end
    end

endmodule
